// File: rtl/dbg_uart_arbiter.sv
// Round-robin arbiter feeding one 8N1 debug UART transmitter (idle-high line).
// Define DBG_UART_TAG_EN to prefix every byte with an ASCII tag frame '0'+requester.
module dbg_uart_arbiter #(
  parameter int NUM_REQ = 3,
  parameter int CLK_DIV = 868
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [NUM_REQ-1:0]     req_valid_i,
  input  logic [8*NUM_REQ-1:0]   req_data_i,
  output logic [NUM_REQ-1:0]     req_ready_o,
  output logic                   uart_tx_o,
  output logic                   busy_o,
  output logic [2:0]             dbg_state_o
);
  localparam int CW = $clog2(CLK_DIV);
  localparam int GW = $clog2(NUM_REQ);
  localparam logic [CW-1:0] BIT_RELOAD = CW'(CLK_DIV - 1);
  localparam logic [GW-1:0] LAST_REQ   = GW'(NUM_REQ - 1);

`ifdef DBG_UART_TAG_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_TAG} state_t;
`else
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  state_t              state;
  logic [CW-1:0]       cnt;
  logic [2:0]          bit_idx;
  logic [7:0]          shift;
  logic [GW-1:0]       last_grant;
  logic [NUM_REQ-1:0]  grant;
  logic [GW-1:0]       grant_idx;
  logic [7:0]          grant_byte;
  logic                found;
  int                  cand;
`ifdef DBG_UART_TAG_EN
  logic [7:0]          hold_byte;
  logic                tag_frame;
`endif

  // Round-robin search starting one past the last winner, wrapping to 0.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    cand      = 0;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = (int'(last_grant) + off) % NUM_REQ;
      if (!found && req_valid_i[cand]) begin
        found           = 1'b1;
        grant[cand]     = 1'b1;
        grant_idx       = GW'(cand);
      end
    end
  end

  assign grant_byte = req_data_i[8*int'(grant_idx) +: 8];

  // Handshake: a byte transfers on the edge where req_valid_i[g] and req_ready_o[g]
  // are both high; ready is only offered in IDLE, to the single round-robin winner.
  assign req_ready_o = (state == S_IDLE && !rst_i) ? grant : '0;
  assign busy_o      = (state != S_IDLE);
  assign dbg_state_o = state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      uart_tx_o  <= 1'b1;
      cnt        <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      last_grant <= LAST_REQ;
`ifdef DBG_UART_TAG_EN
      hold_byte  <= '0;
      tag_frame  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (found) begin
            last_grant <= grant_idx;
            uart_tx_o  <= 1'b0;
            cnt        <= BIT_RELOAD;
            bit_idx    <= '0;
`ifdef DBG_UART_TAG_EN
            shift      <= 8'h30 + 8'(grant_idx);
            hold_byte  <= grant_byte;
            tag_frame  <= 1'b1;
            state      <= S_TAG;
`else
            shift      <= grant_byte;
            state      <= S_START;
`endif
          end
        end
`ifdef DBG_UART_TAG_EN
        S_START, S_TAG: begin
`else
        S_START: begin
`endif
          if (cnt == '0) begin
            state     <= S_DATA;
            cnt       <= BIT_RELOAD;
            uart_tx_o <= shift[0];
            shift     <= {1'b0, shift[7:1]};
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_DATA: begin
          if (cnt == '0) begin
            cnt <= BIT_RELOAD;
            if (bit_idx == 3'd7) begin
              state     <= S_STOP;
              uart_tx_o <= 1'b1;
            end else begin
              bit_idx   <= bit_idx + 3'd1;
              uart_tx_o <= shift[0];
              shift     <= {1'b0, shift[7:1]};
            end
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_STOP: begin
          if (cnt == '0) begin
`ifdef DBG_UART_TAG_EN
            // Tag frame done: start the data frame with no idle gap.
            if (tag_frame) begin
              tag_frame <= 1'b0;
              shift     <= hold_byte;
              uart_tx_o <= 1'b0;
              cnt       <= BIT_RELOAD;
              bit_idx   <= '0;
              state     <= S_START;
            end else begin
              state <= S_IDLE;
            end
`else
            state <= S_IDLE;
`endif
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_dbg_uart_arbiter.sv
// Bench for dbg_uart_arbiter: per-cycle reference model of the serial line plus
// a vector table and hand sequences for round-robin, reset abort and dropped valids.
module tb_dbg_uart_arbiter;
  localparam int NUM_REQ = 3;
  localparam int CLK_DIV = 4;
`ifdef DBG_UART_TAG_EN
  localparam int FRAMES = 2;
`else
  localparam int FRAMES = 1;
`endif
  localparam int FRAME_CYC = 10 * CLK_DIV;
  localparam int GRANT_CYC = FRAMES * FRAME_CYC;
  localparam int MAXC      = 8192;

  logic                   clk_i = 1'b0;
  logic                   rst_i = 1'b1;
  logic [NUM_REQ-1:0]     req_valid_i = '0;
  logic [8*NUM_REQ-1:0]   req_data_i = '0;
  logic [NUM_REQ-1:0]     req_ready_o;
  logic                   uart_tx_o;
  logic                   busy_o;
  logic [2:0]             dbg_state_o;

  always #5 clk_i = ~clk_i;

  dbg_uart_arbiter #(.NUM_REQ(NUM_REQ), .CLK_DIV(CLK_DIV)) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .req_valid_i (req_valid_i),
    .req_data_i  (req_data_i),
    .req_ready_o (req_ready_o),
    .uart_tx_o   (uart_tx_o),
    .busy_o      (busy_o),
    .dbg_state_o (dbg_state_o)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model and scoreboard ----------------
  logic exp_line  [MAXC];
  logic line_hist [MAXC];
  logic busy_hist [MAXC];
  int   m_busy_end = -1;
  int   m_last     = NUM_REQ - 1;
  bit   seen_rst   = 1'b0;
  int   act_g_q[$];
  int   act_c_q[$];
  int   rdy_cnt[NUM_REQ];
  int   mn, mg, mt, mcand;
  bit   mfound;
  logic [NUM_REQ-1:0] mer;
  logic [7:0] mbyte;
  logic [9:0] mframe;

  initial begin
    for (int k = 0; k < MAXC; k++) begin
      exp_line[k]  = 1'b1;
      line_hist[k] = 1'b1;
      busy_hist[k] = 1'b0;
    end
    for (int i = 0; i < NUM_REQ; i++) rdy_cnt[i] = 0;
  end

  always @(negedge clk_i) begin
    mn  = cyc;
    mer = '0;
    if (mn < MAXC) begin
      line_hist[mn] = uart_tx_o;
      busy_hist[mn] = busy_o;
    end
    if (seen_rst) begin
      check("uart_tx", int'(uart_tx_o), (mn < MAXC) ? int'(exp_line[mn]) : 1);
      check("busy", int'(busy_o), int'(mn <= m_busy_end));
    end
    if (rst_i) begin
      if (m_busy_end > mn) m_busy_end = mn;
      for (int k = mn + 1; k < mn + GRANT_CYC + 3 && k < MAXC; k++) exp_line[k] = 1'b1;
      m_last   = NUM_REQ - 1;
      seen_rst = 1'b1;
    end else if (seen_rst && mn > m_busy_end && req_valid_i != '0) begin
      mfound = 1'b0;
      mg     = 0;
      for (int off = 1; off <= NUM_REQ; off++) begin
        mcand = (m_last + off) % NUM_REQ;
        if (!mfound && req_valid_i[mcand]) begin
          mfound = 1'b1;
          mg     = mcand;
        end
      end
      mer[mg] = 1'b1;
      m_last  = mg;
      mt      = mn + 1;
      for (int f = 0; f < FRAMES; f++) begin
        mbyte  = (FRAMES == 2 && f == 0) ? 8'h30 + 8'(mg) : req_data_i[8*mg +: 8];
        mframe = {1'b1, mbyte, 1'b0};
        for (int b = 0; b < 10; b++)
          for (int c = 0; c < CLK_DIV; c++) begin
            if (mt < MAXC) exp_line[mt] = mframe[b];
            mt++;
          end
      end
      m_busy_end = mt - 1;
    end
    if (rst_i || seen_rst) check("req_ready", int'(req_ready_o), int'(mer));
    if (req_ready_o != '0) begin
      for (int i = 0; i < NUM_REQ; i++)
        if (req_ready_o[i]) begin
          act_g_q.push_back(i);
          rdy_cnt[i]++;
        end
      act_c_q.push_back(mn);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int k);
    repeat (k) @(posedge clk_i);
    #1;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    req_valid_i = '0;
    tick(2);
    rst_i = 1'b0;
  endtask

  task automatic wait_ready(output int c, output int g);
    c = -1;
    g = -1;
    for (int k = 0; k < 2 * GRANT_CYC + 20; k++) begin
      @(negedge clk_i);
      if (req_ready_o != '0) begin
        c = cyc;
        for (int i = 0; i < NUM_REQ; i++) if (req_ready_o[i]) g = i;
        break;
      end
    end
    if (c < 0) check("ready_timeout", 0, 1);
  endtask

  typedef struct {
    logic [NUM_REQ-1:0]   valid;
    logic [8*NUM_REQ-1:0] data;
    int                   exp_g;
    logic [7:0]           exp_b;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int c, g, c2, g2, base, bcnt, r1;
    logic [7:0] rx, want;

    tbl[0] = '{3'b001, 24'h0000A5, 0, 8'hA5};
    tbl[1] = '{3'b010, 24'h003C00, 1, 8'h3C};
    tbl[2] = '{3'b100, 24'h410000, 2, 8'h41};
    tbl[3] = '{3'b110, 24'h7E8100, 1, 8'h81};
    tbl[4] = '{3'b111, 24'hFF0055, 0, 8'h55};
    tbl[5] = '{3'b100, 24'h00FFFF, 2, 8'h00};
    tbl[6] = '{3'b011, 24'h00FF01, 0, 8'h01};

    tick(2);
    for (int v = 0; v < 7; v++) begin
      do_reset();
      req_valid_i = tbl[v].valid;
      req_data_i  = tbl[v].data;
      wait_ready(c, g);
      @(posedge clk_i); #1;
      req_valid_i = '0;
      tick(GRANT_CYC + 2);
      check("first_grant", g, tbl[v].exp_g);
      if (c >= 0) begin
        want = (FRAMES == 2) ? 8'h30 + 8'(tbl[v].exp_g) : tbl[v].exp_b;
        for (int b = 0; b < 8; b++) rx[b] = line_hist[c + 1 + (b + 1) * CLK_DIV + CLK_DIV / 2];
        check("start_bit", int'(line_hist[c + 1 + CLK_DIV / 2]), 0);
        check("frame_byte", int'(rx), int'(want));
        check("stop_bit", int'(line_hist[c + 1 + 9 * CLK_DIV + CLK_DIV / 2]), 1);
        bcnt = 0;
        while (bcnt < 3 * GRANT_CYC && busy_hist[c + 1 + bcnt]) bcnt++;
        check("busy_len", bcnt, GRANT_CYC);
      end
    end

    // Continuous requests from all three: rotation 0,1,2,0 with fixed spacing.
    do_reset();
    req_data_i  = 24'hC3_5A_0F;
    req_valid_i = 3'b111;
    base = act_c_q.size();
    for (int k = 0; k < 5 * GRANT_CYC + 20 && act_c_q.size() < base + 4; k++) tick(1);
    req_valid_i = '0;
    check("rr_count", act_c_q.size() - base, 4);
    if (act_c_q.size() >= base + 4) begin
      for (int i = 0; i < 4; i++) check("rr_order", act_g_q[base + i], (i == 3) ? 0 : i);
      for (int i = 1; i < 4; i++) check("rr_spacing", act_c_q[base + i] - act_c_q[base + i - 1], GRANT_CYC + 1);
    end
    tick(GRANT_CYC + 2);

    // Reset at cycle 13 of a frame aborts it; requester 1 wins next.
    do_reset();
    req_data_i  = 24'h22_11_A5;
    req_valid_i = 3'b001;
    wait_ready(c, g);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    tick(12);
    rst_i = 1'b1;
    tick(1);
    rst_i = 1'b0;
    req_valid_i = 3'b110;
    wait_ready(c2, g2);
    check("abort_tx_idle", int'(uart_tx_o), 1);
    check("abort_busy", int'(busy_o), 0);
    check("abort_regrant", g2, 1);
    check("abort_regrant_cycle", c2 - c, 14);
    @(posedge clk_i); #1;
    req_valid_i = '0;
    tick(GRANT_CYC + 2);

    // Requester 1 valid comes and goes during frame 0: never granted.
    do_reset();
    req_data_i  = 24'h33_77_5C;
    req_valid_i = 3'b001;
    r1 = rdy_cnt[1];
    wait_ready(c, g);
    @(posedge clk_i); #1;
    req_valid_i = 3'b010;
    tick(10);
    req_valid_i = '0;
    tick(GRANT_CYC);
    @(negedge clk_i);
    check("dropped_valid_ready1", rdy_cnt[1] - r1, 0);
    check("idle_after_tx", int'(uart_tx_o), 1);
    check("idle_after_busy", int'(busy_o), 0);
    @(posedge clk_i); #1;

    // Randomized traffic with rare resets, checked cycle-by-cycle by the model.
    do_reset();
    for (int k = 0; k < 2500; k++) begin
      req_valid_i = NUM_REQ'($urandom_range(0, 7));
      req_data_i  = 24'($urandom);
      rst_i       = ($urandom_range(0, 399) == 0);
      tick(1);
    end
    rst_i = 1'b0;
    req_valid_i = '0;
    tick(GRANT_CYC + 5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/dbg_uart_arbiter.md
DBG_UART_ARBITER -- requirements
Module: dbg_uart_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 3: number of debug byte requesters, legal range 2..8.
REQ-002 SHALL have parameter CLK_DIV, default 868: clk_i cycles per UART bit, legal range >= 2.
REQ-003 SHALL have port clk_i, input, 1 bit: single clock. All logic on the rising edge.
REQ-004 SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port req_valid_i, input, NUM_REQ bits: per-requester byte valid.
REQ-006 SHALL have port req_data_i, input, 8*NUM_REQ bits: byte for requester i at bits [8i+7:8i].
REQ-007 SHALL have port req_ready_o, output, NUM_REQ bits: one-hot acceptance strobe.
REQ-008 SHALL have port uart_tx_o, output, 1 bit: serial line that drives the board dbg_uart_tx pin; idle high.
REQ-009 SHALL have port busy_o, output, 1 bit: high whenever the FSM is not in IDLE.

Function
REQ-010 SHALL implement an FSM with states IDLE, START, DATA and STOP, plus TAG when DBG_UART_TAG_EN is defined.
REQ-011 In IDLE with any req_valid_i set, SHALL grant exactly one requester by round-robin.
  - Search starts at last_grant+1 and wraps from NUM_REQ-1 to 0.
REQ-012 The handshake SHALL complete in the same cycle as the grant:
  - req_ready_o[g] = (state==IDLE) & grant[g], combinational.
  - req_data_i byte g is latched into the shift register on that edge.
  - last_grant is set to g on that edge.
REQ-013 req_ready_o SHALL be zero in every state other than IDLE, and never has more than one bit set.
REQ-014 Frame format SHALL be: start bit 0, then 8 data bits LSB first, then 1 stop bit 1. Each bit is held for exactly CLK_DIV cycles.
REQ-015 Latency SHALL be: uart_tx_o falls on the cycle after the handshake edge. A frame lasts 10*CLK_DIV cycles.
REQ-016 Bit timing SHALL use a down-counter of width $clog2(CLK_DIV), reloaded to CLK_DIV-1 on every bit boundary.
REQ-017 A 3-bit bit index SHALL count 0..7 in DATA. The FSM moves to STOP after index 7 expires.
REQ-018 After the last STOP cycle the FSM SHALL enter IDLE and may grant again on that IDLE cycle.
  - Consecutive frames are therefore separated by exactly one idle-high cycle.
REQ-019 A requester that deasserts valid before being granted SHALL lose its place with no side effects. Valid is not required to be sticky.
REQ-020 Changes on req_valid_i or req_data_i during a frame SHALL NOT affect the frame in flight.

Reset
REQ-021 While rst_i is high at a clock edge, the following SHALL hold on the next cycle:
  - state = IDLE, uart_tx_o = 1, busy_o = 0, req_ready_o = 0.
  - last_grant = NUM_REQ-1, so that requester 0 wins first.
  - Counters are cleared.
REQ-022 Reset asserted mid-frame SHALL abort the frame: the line returns high on the next cycle and the aborted byte is dropped, not retransmitted.
REQ-023 req_ready_o SHALL be forced to 0 in any cycle where rst_i is high.

Configuration
REQ-024 Macro DBG_UART_TAG_EN defined: each grant SHALL send two frames back-to-back.
  - First frame: tag byte ASCII '0'+g (8'h30+g).
  - Second frame: the data byte.
  - The two frames are separated by no idle cycle, and busy_o stays high across both.
  - Total time is 20*CLK_DIV cycles.
REQ-025 Macro DBG_UART_TAG_EN undefined: the TAG state and the tag logic SHALL be absent, and each grant sends one frame.

Verification
REQ-026 CLK_DIV=4, req_valid_i=3'b001, byte 8'hA5:
  - Expect ready[0] pulsed for 1 cycle.
  - Expect uart_tx_o to show the bit sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles.
  - Expect busy_o high for 40 cycles.
REQ-027 req_valid_i=3'b111 held continuously:
  - Expect grants in order 0,1,2,0.
  - Each ready pulse follows the previous one by exactly 10*CLK_DIV+1 cycles.
REQ-028 rst_i pulsed at cycle 13 of a frame with CLK_DIV=4:
  - Expect uart_tx_o=1 and busy_o=0 on the next cycle.
  - After release with req_valid_i=3'b110, expect requester 1 granted first.
REQ-029 DBG_UART_TAG_EN defined, req_valid_i=3'b100, byte 8'h41:
  - Expect frames 8'h32 then 8'h41 contiguously, 80 cycles total at CLK_DIV=4.
REQ-030 Valid on requester 1 toggled low before grant while frame 0 is active:
  - Expect no ready[1] pulse.
  - Expect uart_tx_o idle high after frame 0.
